branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
- Branch/jump resolution and PC-redirect sequencer for the MIPS core, sitting between decode (ID) and fetch (IF).
- Accepts one decoded control-transfer per handshake and computes the target. Branch offsets use sign-extend then shift-left-2 word-offset scaling.
- Evaluates the condition, waits until the delay-slot instruction has been fetched, then holds a redirect request to IF until it is accepted.
- Keeps branch/taken performance counters for the perf test.

Parameters:
- OP_W, 4, width of br_op encoding (values defined in shared package)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- br_valid  in  1  ID presents a control-transfer instruction
- br_ready  out  1  controller can accept (IDLE only)
- br_op  in  OP_W  BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ, J, JAL, JR
- br_pc  in  32  PC of the branch instruction
- br_imm  in  16  I-type offset field
- br_index  in  26  J-type instr_index field
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- slot_fetched  in  1  single-cycle pulse: IF accepted the delay-slot PC (br_pc+4)
- flush  in  1  exception/ERET flush; aborts pending work
- redir_valid  out  1  redirect request to IF
- redir_pc  out  32  redirect target
- redir_ready  in  1  IF accepts redirect
- jr_adel  out  1  one-cycle pulse: JR target misaligned
- br_cnt  out  CNT_W  accepted branches/jumps
- taken_cnt  out  CNT_W  taken branches/jumps

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; redir_valid=0, redir_pc=0, jr_adel=0, br_cnt=0, taken_cnt=0, slot flag=0. br_ready=1 once reset is released.
- States: IDLE, WAIT_SLOT, REDIRECT.
- br_ready = (state==IDLE) & ~flush.
- Accept condition: br_valid & br_ready. In the accept cycle, compute and register target, taken and slot-seen:
  - Branch target: br_pc + 4 + sext(br_imm)<<2, truncated modulo 2^32 (wrap is legal).
  - J/JAL target: {(br_pc+4)[31:28], br_index, 2'b00}.
  - JR target: rs_val.
  - Conditions (signed compares): BEQ rs==rt; BNE rs!=rt; BGEZ rs>=0; BGTZ rs>0; BLEZ rs<=0; BLTZ rs<0. J, JAL and JR are always taken.
- Transitions on accept:
  - Not taken -> stay IDLE; br_cnt+1.
  - JR with rs_val[1:0]!=0 -> jr_adel pulses the next cycle; stay IDLE; br_cnt+1; taken_cnt unchanged; no redirect.
  - Taken and slot_fetched high in the same cycle -> REDIRECT.
  - Taken otherwise -> WAIT_SLOT.
  - Both counters +1 for any taken case.
- WAIT_SLOT: on slot_fetched -> REDIRECT next cycle. No timeout.
- REDIRECT: redir_valid=1 and redir_pc stable until redir_valid & redir_ready, then IDLE in the next cycle. No new accept in that handoff cycle.
- Illegal br_op value is treated as not taken and not counted.
- flush has priority over everything:
  - Any state -> IDLE next cycle; redir_valid drops next cycle.
  - A redirect handshake in the same cycle as flush is still considered complete by IF; the controller simply returns to IDLE.
  - Counters are not rolled back.
- Counters wrap from 2^CNT_W-1 to 0.
- Latency: accept -> redir_valid is 1 cycle minimum (slot already fetched), otherwise 1 cycle after the slot_fetched pulse.
- Asynchronous reset mid-REDIRECT drops redir_valid immediately.

Decomposition:
- Shared package (cpu_defs_pkg): br_op encodings, state enumeration, RESET_PC constant.
- One natural sub-module, br_target_calc: purely combinational target, taken and misalign computation. The FSM and counters stay in the top module.

Test Plan:
- BEQ, br_pc=0xBFC00010, imm=0x0004, rs=rt=5, slot_fetched 2 cycles later -> WAIT_SLOT, then redir_pc=0xBFC00024 held through 3 cycles of redir_ready=0; br_cnt=1, taken_cnt=1.
- BNE rs=rt=7 -> no redir_valid, br_ready stays 1, br_cnt=1, taken_cnt=0.
- Backward BLTZ imm=0xFFFF, br_pc=0x00000000, rs=0x80000000, slot_fetched in accept cycle -> redir_valid next cycle, redir_pc=0x00000000 (wrap of 0+4-4).
- J br_pc=0xBFC00100, index=0x0000040 -> redir_pc=0xB0000100; JR rs=0x80000002 -> jr_adel single pulse, no redirect.
- flush asserted during WAIT_SLOT and again during REDIRECT with redir_ready=0 -> IDLE next cycle, redir_valid=0, counters retain values.
- resetn pulled low mid-REDIRECT -> redir_valid=0 immediately, counters=0; after release the first br_valid is accepted normally.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared MIPS core definitions: branch op encodings, redirect FSM states and
// the branch-offset helper used by the target calculator.
package cpu_defs_pkg;

  localparam logic [31:0] ResetPc = 32'hBFC0_0000;

  localparam logic [3:0] OpBeq  = 4'd0;
  localparam logic [3:0] OpBne  = 4'd1;
  localparam logic [3:0] OpBgez = 4'd2;
  localparam logic [3:0] OpBgtz = 4'd3;
  localparam logic [3:0] OpBlez = 4'd4;
  localparam logic [3:0] OpBltz = 4'd5;
  localparam logic [3:0] OpJ    = 4'd6;
  localparam logic [3:0] OpJal  = 4'd7;
  localparam logic [3:0] OpJr   = 4'd8;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StWaitSlot = 2'd1;
  localparam logic [1:0] StRedirect = 2'd2;

  // Word offset: sign-extend the 16-bit field, then scale by 4.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// ID/IF-facing handshake bundle of the branch redirect controller.
interface branch_redirect_ctrl_if #(
  parameter int unsigned OP_W = 4
);
  logic            br_valid;
  logic            br_ready;
  logic [OP_W-1:0] br_op;
  logic [31:0]     br_pc;
  logic [15:0]     br_imm;
  logic [25:0]     br_index;
  logic [31:0]     rs_val;
  logic [31:0]     rt_val;
  logic            slot_fetched;
  logic            redir_valid;
  logic [31:0]     redir_pc;
  logic            redir_ready;

  modport master (
    output br_valid, br_op, br_pc, br_imm, br_index, rs_val, rt_val, slot_fetched, redir_ready,
    input  br_ready, redir_valid, redir_pc
  );

  modport slave (
    input  br_valid, br_op, br_pc, br_imm, br_index, rs_val, rt_val, slot_fetched, redir_ready,
    output br_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/br_target_calc.sv
// Combinational branch/jump resolution: target address, taken condition,
// op legality and JR target misalignment.
module br_target_calc
  import cpu_defs_pkg::*;
#(
  parameter int unsigned OP_W = 4
) (
  input  logic [OP_W-1:0] br_op,
  input  logic [31:0]     br_pc,
  input  logic [15:0]     br_imm,
  input  logic [25:0]     br_index,
  input  logic [31:0]     rs_val,
  input  logic [31:0]     rt_val,
  output logic [31:0]     target,
  output logic            taken,
  output logic            legal,
  output logic            jr_misalign
);

  logic [31:0] pc_plus4;
  assign pc_plus4 = br_pc + 32'd4;

  always_comb begin
    target      = pc_plus4 + br_offset(br_imm);
    taken       = 1'b0;
    legal       = 1'b1;
    jr_misalign = 1'b0;
    // Signed compares against zero reduce to sign-bit tests.
    case (br_op)
      OP_W'(OpBeq):  taken = (rs_val == rt_val);
      OP_W'(OpBne):  taken = (rs_val != rt_val);
      OP_W'(OpBgez): taken = ~rs_val[31];
      OP_W'(OpBgtz): taken = ~rs_val[31] & (rs_val != 32'd0);
      OP_W'(OpBlez): taken = rs_val[31] | (rs_val == 32'd0);
      OP_W'(OpBltz): taken = rs_val[31];
      OP_W'(OpJ), OP_W'(OpJal): begin
        taken  = 1'b1;
        target = {pc_plus4[31:28], br_index, 2'b00};
      end
      OP_W'(OpJr): begin
        taken       = 1'b1;
        target      = rs_val;
        jr_misalign = |rs_val[1:0];
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: accepts a control transfer from ID, waits for the
// delay slot to be fetched, then holds a redirect to IF until accepted.
module branch_redirect_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  branch_redirect_ctrl_if.slave bus,
  input  logic                flush,
  output logic                jr_adel,
  output logic [CNT_W-1:0]    br_cnt,
  output logic [CNT_W-1:0]    taken_cnt
);

  logic [1:0]       state_q, state_d;
  logic [31:0]      target_q, target_d;
  logic             jr_adel_q, jr_adel_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic [31:0] calc_target;
  logic        calc_taken, calc_legal, calc_misalign;
  logic        accept, counted, redirect;

  br_target_calc #(
    .OP_W(OP_W)
  ) u_calc (
    .br_op      (bus.br_op),
    .br_pc      (bus.br_pc),
    .br_imm     (bus.br_imm),
    .br_index   (bus.br_index),
    .rs_val     (bus.rs_val),
    .rt_val     (bus.rt_val),
    .target     (calc_target),
    .taken      (calc_taken),
    .legal      (calc_legal),
    .jr_misalign(calc_misalign)
  );

  assign bus.br_ready    = (state_q == StIdle) & ~flush;
  assign bus.redir_valid = (state_q == StRedirect);
  assign bus.redir_pc    = target_q;
  assign jr_adel         = jr_adel_q;
  assign br_cnt          = br_cnt_q;
  assign taken_cnt       = taken_cnt_q;

  assign accept   = bus.br_valid & bus.br_ready;
  assign counted  = accept & calc_legal;
  assign redirect = counted & calc_taken & ~calc_misalign;

  always_comb begin
    state_d     = state_q;
    target_d    = redirect ? calc_target : target_q;
    jr_adel_d   = counted & calc_misalign;
    br_cnt_d    = br_cnt_q + (counted ? CNT_W'(1) : CNT_W'(0));
    taken_cnt_d = taken_cnt_q + (redirect ? CNT_W'(1) : CNT_W'(0));
    unique case (state_q)
      StIdle:     if (redirect) state_d = bus.slot_fetched ? StRedirect : StWaitSlot;
      StWaitSlot: if (bus.slot_fetched) state_d = StRedirect;
      StRedirect: if (bus.redir_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    // Flush aborts pending work; counters are deliberately not rolled back.
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      target_q    <= 32'd0;
      jr_adel_q   <= 1'b0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      jr_adel_q   <= jr_adel_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

endmodule
